// File: rtl/gemm_pkg.sv
// Shared constants, FSM encoding and the requantization helper for the GEMM write-back path.
package gemm_pkg;

  localparam int unsigned PE_SIZE         = 16;
  localparam int unsigned ACC_WIDTH       = 32;
  localparam int unsigned OUT_WIDTH       = 8;
  localparam int unsigned MEM2_DATA_WIDTH = PE_SIZE * OUT_WIDTH;

  localparam int OUT_MIN = -128;
  localparam int OUT_MAX = 127;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } wr_state_e;

  // Floor shift (arithmetic), then clamp into the signed output range.
  function automatic logic [OUT_WIDTH-1:0] requant(input logic [ACC_WIDTH-1:0] psum,
                                                   input logic [4:0]           shift);
    logic signed [ACC_WIDTH-1:0] shifted;
    shifted = $signed(psum) >>> shift;
    if (shifted > $signed(ACC_WIDTH'(OUT_MAX))) begin
      return OUT_WIDTH'(OUT_MAX);
    end else if (shifted < $signed(ACC_WIDTH'(OUT_MIN))) begin
      return OUT_WIDTH'(OUT_MIN);
    end
    return shifted[OUT_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth register chain carrying a data word and its valid bit; DEPTH=0 is a wire.
module skew_delay_line #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign valid_o        = valid_i;
    assign data_o         = data_i;
  end else begin : g_chain
    logic [WIDTH-1:0] data_q  [DEPTH];
    logic [WIDTH-1:0] data_d  [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;

    always_comb begin
      data_d[0]  = data_i;
      valid_d[0] = valid_i;
      for (int i = 1; i < DEPTH; i++) begin
        data_d[i]  = data_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) begin
          data_q[i] <= '0;
        end
        valid_q <= '0;
      end else begin
        data_q  <= data_d;
        valid_q <= valid_d;
      end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign data_o  = data_q[DEPTH-1];
  end

endmodule

// File: rtl/gemm_result_writer.sv
// De-skews PE-array psums into aligned rows, requantizes to int8 and writes one row per cycle
// into mem2 port 0 under a start/done tile controller.
module gemm_result_writer
  import gemm_pkg::*;
#(
  parameter int unsigned MEM2_DEPTH      = 896,
  parameter int unsigned MEM2_ADDR_WIDTH = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_i,
  input  logic [MEM2_ADDR_WIDTH-1:0]     base_addr_i,
  input  logic [MEM2_ADDR_WIDTH-1:0]     num_rows_i,
  input  logic [4:0]                     shift_i,
  input  logic [PE_SIZE*ACC_WIDTH-1:0]   psum_i,
  input  logic [PE_SIZE-1:0]             psum_valid_i,
  output logic [MEM2_ADDR_WIDTH-1:0]     mem2_addr0,
  output logic                           mem2_ce0,
  output logic                           mem2_we0,
  output logic [MEM2_DATA_WIDTH-1:0]     mem2_d0,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           err_o
);

  localparam logic [MEM2_ADDR_WIDTH:0] DepthLimit = (MEM2_ADDR_WIDTH+1)'(MEM2_DEPTH);

  logic [ACC_WIDTH-1:0]       lane_psum [PE_SIZE];
  logic [PE_SIZE-1:0]         lane_valid;
  logic [MEM2_DATA_WIDTH-1:0] row_data;
  logic                       row_valid, row_partial;
  logic [MEM2_ADDR_WIDTH-1:0] wr_addr;
  logic                       addr_oob, start_accept, err_event;

  wr_state_e                  state_q, state_d;
  logic [MEM2_ADDR_WIDTH-1:0] base_q, base_d, num_rows_q, num_rows_d, row_cnt_q, row_cnt_d;
  logic [4:0]                 shift_q, shift_d;
  logic [MEM2_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [MEM2_DATA_WIDTH-1:0] data_q, data_d;
  logic                       ce_q, ce_d, busy_q, busy_d, done_q, done_d, err_q, err_d;

  // Lane c is PE_SIZE-1-c cycles early relative to the last lane.
  for (genvar c = 0; c < PE_SIZE; c++) begin : g_lane
    skew_delay_line #(
      .WIDTH(ACC_WIDTH),
      .DEPTH(PE_SIZE - 1 - c)
    ) u_skew (
      .clk    (clk),
      .rst    (rst),
      .valid_i(psum_valid_i[c]),
      .data_i (psum_i[c*ACC_WIDTH +: ACC_WIDTH]),
      .valid_o(lane_valid[c]),
      .data_o (lane_psum[c])
    );
  end

  always_comb begin
    row_data = '0;
    for (int c = 0; c < PE_SIZE; c++) begin
      row_data[c*OUT_WIDTH +: OUT_WIDTH] = requant(lane_psum[c], shift_q);
    end
  end

  assign row_valid    = &lane_valid;
  assign row_partial  = (|lane_valid) & ~row_valid;
  assign wr_addr      = base_q + row_cnt_q;
  assign addr_oob     = {1'b0, wr_addr} >= DepthLimit;
  assign start_accept = (state_q == StIdle) && start_i;
  assign err_event    = row_partial || (row_valid && (state_q != StRun || addr_oob));

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    num_rows_d = num_rows_q;
    shift_d    = shift_q;
    row_cnt_d  = row_cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    ce_d       = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          base_d     = base_addr_i;
          num_rows_d = num_rows_i;
          shift_d    = shift_i;
          row_cnt_d  = '0;
          state_d    = (num_rows_i == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (row_valid) begin
          // Out-of-range rows still consume a row slot so later rows keep their addresses.
          if (!addr_oob) begin
            ce_d   = 1'b1;
            addr_d = wr_addr;
            data_d = row_data;
          end
          row_cnt_d = row_cnt_q + MEM2_ADDR_WIDTH'(1);
          if (row_cnt_q == num_rows_q - MEM2_ADDR_WIDTH'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
    err_d  = (start_accept ? 1'b0 : err_q) | err_event;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      base_q     <= '0;
      num_rows_q <= '0;
      shift_q    <= '0;
      row_cnt_q  <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      ce_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      num_rows_q <= num_rows_d;
      shift_q    <= shift_d;
      row_cnt_q  <= row_cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      ce_q       <= ce_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign mem2_addr0 = addr_q;
  assign mem2_ce0   = ce_q;
  assign mem2_we0   = ce_q;
  assign mem2_d0    = data_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_gemm_result_writer.sv
// Directed bench: a per-cycle expectation timeline built from tile-level rules, checked every cycle.
module tb_gemm_result_writer;

  localparam int NCYC    = 260;
  localparam int END_CYC = 240;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic [9:0]   base_addr_i, num_rows_i;
  logic [4:0]   shift_i;
  logic [511:0] psum_i;
  logic [15:0]  psum_valid_i;
  logic [9:0]   mem2_addr0;
  logic         mem2_ce0, mem2_we0;
  logic [127:0] mem2_d0;
  logic         busy_o, done_o, err_o;

  gemm_result_writer dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .num_rows_i  (num_rows_i),
    .shift_i     (shift_i),
    .psum_i      (psum_i),
    .psum_valid_i(psum_valid_i),
    .mem2_addr0  (mem2_addr0),
    .mem2_ce0    (mem2_ce0),
    .mem2_we0    (mem2_we0),
    .mem2_d0     (mem2_d0),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  // Stimulus per cycle.
  bit           rst_s [NCYC];
  bit           st_s  [NCYC];
  logic [9:0]   base_s[NCYC];
  logic [9:0]   n_s   [NCYC];
  logic [4:0]   sh_s  [NCYC];
  logic [15:0]  v_s   [NCYC];
  logic [511:0] p_s   [NCYC];
  // Expectations per cycle.
  bit           exp_wr  [NCYC];
  logic [9:0]   exp_wa  [NCYC];
  logic [127:0] exp_wd  [NCYC];
  bit           exp_done[NCYC];
  bit           exp_busy[NCYC];
  bit           err_set [NCYC];
  bit           err_clr [NCYC];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  function automatic logic [7:0] ref_requant(input logic [31:0] v, input int sh);
    longint x, p, q;
    logic [7:0] r;
    x = longint'($signed(v));
    p = longint'(1) << sh;
    if (x >= 0) q = x / p;
    else        q = -((-x + p - 1) / p);
    if (q > 127)  q = 127;
    if (q < -128) q = -128;
    r = q[7:0];
    return r;
  endfunction

  function automatic logic [127:0] exp_row(input logic [511:0] row, input int sh);
    logic [127:0] r;
    for (int c = 0; c < 16; c++) r[c*8 +: 8] = ref_requant(row[c*32 +: 32], sh);
    return r;
  endfunction

  function automatic logic [511:0] uni(input int v);
    logic [31:0] w;
    w = 32'(v);
    return {16{w}};
  endfunction

  task automatic sched_start(input int s, input int base, input int n, input int sh,
                             input bit accepted);
    st_s[s]   = 1'b1;
    base_s[s] = 10'(base);
    n_s[s]    = 10'(n);
    sh_s[s]   = 5'(sh);
    if (accepted) err_clr[s+1] = 1'b1;
  endtask

  // Row whose last lane is driven in cycle k; lane c goes out 15-c cycles earlier.
  task automatic sched_row(input int k, input logic [511:0] row, input logic [15:0] mask);
    for (int c = 0; c < 16; c++) begin
      v_s[k-15+c][c]          = mask[c];
      p_s[k-15+c][c*32 +: 32] = row[c*32 +: 32];
    end
  endtask

  task automatic sched_write(input int k, input int addr, input logic [511:0] row, input int sh);
    exp_wr[k+1] = 1'b1;
    exp_wa[k+1] = 10'(addr);
    exp_wd[k+1] = exp_row(row, sh);
  endtask

  task automatic sched_busy(input int a, input int b);
    for (int i = a; i <= b; i++) exp_busy[i] = 1'b1;
  endtask

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
    end
  endtask

  task automatic plan();
    logic [511:0] rq;
    logic [31:0]  rv [4];
    for (int i = 0; i < NCYC; i++) begin
      base_s[i] = '0; n_s[i] = '0; sh_s[i] = '0; v_s[i] = '0; p_s[i] = '0;
      exp_wa[i] = '0; exp_wd[i] = '0;
    end
    rst_s[0] = 1'b1;
    rst_s[1] = 1'b1;
    // Basic tile.
    sched_start(5, 5, 3, 0, 1'b1);
    for (int r = 0; r < 3; r++) begin
      sched_row(20 + r, uni(r + 1), 16'hFFFF);
      sched_write(20 + r, 5 + r, uni(r + 1), 0);
    end
    exp_done[23] = 1'b1;
    sched_busy(6, 23);
    // Requantization corners.
    rv = '{32'h0000_0810, 32'hFFFF_F000, 32'h0000_0FFF, 32'hFFFF_FFFF};
    for (int c = 0; c < 16; c++) rq[c*32 +: 32] = rv[c % 4];
    sched_start(30, 100, 1, 4, 1'b1);
    sched_row(50, rq, 16'hFFFF);
    sched_write(50, 100, rq, 4);
    exp_done[51] = 1'b1;
    sched_busy(31, 51);
    // Rows past the end of mem2.
    sched_start(60, 894, 4, 0, 1'b1);
    for (int r = 0; r < 4; r++) sched_row(80 + r, uni(r + 10), 16'hFFFF);
    sched_write(80, 894, uni(10), 0);
    sched_write(81, 895, uni(11), 0);
    err_set[83] = 1'b1;
    err_set[84] = 1'b1;
    exp_done[84] = 1'b1;
    sched_busy(61, 84);
    // Lane 7 missing on one row.
    sched_start(90, 200, 3, 0, 1'b1);
    sched_row(110, uni(20), 16'hFFFF);
    sched_row(111, uni(21), 16'hFF7F);
    sched_row(112, uni(22), 16'hFFFF);
    sched_row(113, uni(23), 16'hFFFF);
    sched_write(110, 200, uni(20), 0);
    err_set[112] = 1'b1;
    sched_write(112, 201, uni(22), 0);
    sched_write(113, 202, uni(23), 0);
    exp_done[114] = 1'b1;
    sched_busy(91, 114);
    // Empty tile.
    sched_start(120, 300, 0, 0, 1'b1);
    exp_done[121] = 1'b1;
    sched_busy(121, 121);
    // Second start while running is ignored.
    sched_start(130, 310, 2, 0, 1'b1);
    sched_start(135, 400, 5, 3, 1'b0);
    sched_row(150, uni(30), 16'hFFFF);
    sched_row(151, uni(31), 16'hFFFF);
    sched_write(150, 310, uni(30), 0);
    sched_write(151, 311, uni(31), 0);
    exp_done[152] = 1'b1;
    sched_busy(131, 152);
    // Row while idle.
    sched_row(170, uni(40), 16'hFFFF);
    err_set[171] = 1'b1;
    // Reset mid-tile, then a fresh tile.
    sched_start(180, 500, 4, 0, 1'b1);
    sched_row(200, uni(50), 16'hFFFF);
    sched_row(201, uni(51), 16'hFFFF);
    sched_write(200, 500, uni(50), 0);
    sched_write(201, 501, uni(51), 0);
    sched_busy(181, 203);
    rst_s[203] = 1'b1;
    sched_start(210, 600, 1, 0, 1'b1);
    sched_row(230, uni(60), 16'hFFFF);
    sched_write(230, 600, uni(60), 0);
    exp_done[231] = 1'b1;
    sched_busy(211, 231);
  endtask

  task automatic apply(input int c);
    rst          = rst_s[c];
    start_i      = st_s[c];
    base_addr_i  = base_s[c];
    num_rows_i   = n_s[c];
    shift_i      = sh_s[c];
    psum_valid_i = v_s[c];
    psum_i       = p_s[c];
  endtask

  initial begin
    plan();
    apply(0);
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (cyc < NCYC) apply(cyc);
    end
  end

  // Model state: address/data hold last write, err is sticky between its events.
  logic [9:0]   m_addr;
  logic [127:0] m_d;
  bit           m_err;

  always @(negedge clk) begin
    if (cyc >= 1 && cyc < NCYC) begin
      if (rst_s[cyc-1]) begin
        m_addr = '0;
        m_d    = '0;
        m_err  = 1'b0;
      end
      if (err_clr[cyc]) m_err = 1'b0;
      if (err_set[cyc]) m_err = 1'b1;
      if (exp_wr[cyc]) begin
        m_addr = exp_wa[cyc];
        m_d    = exp_wd[cyc];
      end
      check("ce0", 128'(mem2_ce0), 128'(exp_wr[cyc]));
      check("we0", 128'(mem2_we0), 128'(exp_wr[cyc]));
      check("addr0", 128'(mem2_addr0), 128'(m_addr));
      check("d0", mem2_d0, m_d);
      check("done", 128'(done_o), 128'(exp_done[cyc]));
      check("busy", 128'(busy_o), 128'(exp_busy[cyc]));
      check("err", 128'(err_o), 128'(m_err));
      case (cyc)
        21:  begin
          check("lit_basic_d0", mem2_d0, {16{8'h01}});
          check("lit_basic_addr", 128'(mem2_addr0), 128'd5);
        end
        23:  check("lit_basic_done", 128'(done_o), 128'd1);
        51:  check("lit_requant_d0", mem2_d0, {4{32'hFF7F_807F}});
        82:  check("lit_wrap_addr", 128'(mem2_addr0), 128'd895);
        85:  check("lit_wrap_err", 128'(err_o), 128'd1);
        114: check("lit_skew_addr", 128'(mem2_addr0), 128'd202);
        121: check("lit_empty_done", 128'(done_o), 128'd1);
        171: check("lit_idle_err", 128'(err_o), 128'd1);
        204: begin
          check("lit_rst_busy", 128'(busy_o), 128'd0);
          check("lit_rst_d0", mem2_d0, 128'd0);
        end
        231: check("lit_fresh_addr", 128'(mem2_addr0), 128'd600);
        default: ;
      endcase
    end
  end

  initial begin
    wait (cyc >= END_CYC);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
